reg_bank: RTL

REG_BANK -- requirements
Module: reg_bank

---
 rtl/proc_pkg.sv | 38 +++
 rtl/reg_cell.sv | 47 ++++
 rtl/reg_bank.sv | 66 ++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants: control-word bit positions, default widths,
// register indices and the register-operation encoding used by reg_bank.
package proc_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_SEL_W  = 3;

  localparam int unsigned CTRL_INC    = 0;
  localparam int unsigned CTRL_RST    = 1;
  localparam int unsigned CTRL_WTR    = 2;
  localparam int unsigned CTRL_OPR_LO = 5;
  localparam int unsigned CTRL_OPR_HI = 7;

  localparam int unsigned R0 = 0;
  localparam int unsigned R1 = 1;
  localparam int unsigned R2 = 2;
  localparam int unsigned R3 = 3;
  localparam int unsigned R4 = 4;
  localparam int unsigned R5 = 5;
  localparam int unsigned R6 = 6;
  localparam int unsigned R7 = 7;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_INC  = 2'd1,
    OP_WTR  = 2'd2,
    OP_RST  = 2'd3
  } reg_op_e;

  // Collapse the three decoded enables into one op; clear beats write beats increment.
  function automatic reg_op_e decode_op(input logic rst, input logic wtr, input logic inc);
    if (rst)      return OP_RST;
    else if (wtr) return OP_WTR;
    else if (inc) return OP_INC;
    else          return OP_NONE;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One general-purpose register with clear/write/increment and a registered zero flag.
// REG_BANK_WRAP_EN adds wrap_c, high when this cycle's increment rolls over.
module reg_cell
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  reg_op_e           op,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              zero
`ifdef REG_BANK_WRAP_EN
  ,
  output logic              wrap_c
`endif
);

  logic [DATA_W-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    unique case (op)
      OP_RST:  q_nxt = '0;
      OP_WTR:  q_nxt = d;
      OP_INC:  q_nxt = q + DATA_W'(1);
      default: q_nxt = q;
    endcase
  end

`ifdef REG_BANK_WRAP_EN
  assign wrap_c = (op == OP_INC) && (&q);
`endif

  // zero is derived from the next value so it never lags the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      zero <= 1'b1;
    end else begin
      q    <= q_nxt;
      zero <= (q_nxt == '0);
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Bank of NUM_REGS registers addressed by sel, with a combinational read port.
// Define REG_BANK_WRAP_EN to get the registered increment-overflow pulse on wrap.
module reg_bank
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SEL_W    = DEF_SEL_W,
  parameter int unsigned NUM_REGS = 1 << SEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_en,
  input  logic                rst_en,
  input  logic                wtr_en,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DATA_W-1:0]   bus_in,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [DATA_W-1:0]   bus_out,
  output logic [NUM_REGS-1:0] zero
`ifdef REG_BANK_WRAP_EN
  ,
  output logic                wrap
`endif
);

  reg_op_e           op;
  reg_op_e           cell_op [NUM_REGS];
  logic [DATA_W-1:0] regs    [NUM_REGS];
`ifdef REG_BANK_WRAP_EN
  logic [NUM_REGS-1:0] wrap_vec;
`endif

  assign op = decode_op(rst_en, wtr_en, inc_en);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    assign cell_op[i] = (sel == SEL_W'(i)) ? op : OP_NONE;

    reg_cell #(.DATA_W(DATA_W)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .op     (cell_op[i]),
      .d      (bus_in),
      .q      (regs[i]),
      .zero   (zero[i])
`ifdef REG_BANK_WRAP_EN
      ,
      .wrap_c (wrap_vec[i])
`endif
    );
  end

  // Read port has no bypass: a same-cycle write shows up on the next cycle.
  assign bus_out = regs[rd_sel];

`ifdef REG_BANK_WRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= |wrap_vec;
  end
`endif

  sel_known_a: assert property (@(posedge clk) disable iff (!rst_n)
    (inc_en || rst_en || wtr_en) |-> !$isunknown(sel))
    else $error("reg_bank: sel is unknown while an enable is asserted");

endmodule
